// File: rtl/edge_capture_bank_pkg.sv
// Shared types, default widths and the per-mode edge select used by edge_capture_bank.
// The optional timestamp path is enabled by defining EDGE_CAP_TSTAMP_EN.
package edge_cap_pkg;

    localparam int EC_NCH_DEF = 4;
    localparam int EC_DW_DEF  = 7;
    localparam int EC_TSW_DEF = 16;

    typedef enum logic [1:0] {
        EC_OFF  = 2'b00,
        EC_RISE = 2'b01,
        EC_FALL = 2'b10,
        EC_BOTH = 2'b11
    } ec_mode_e;

    function automatic logic ec_hit(input ec_mode_e mode, input logic trig, input logic trig_q);
        logic v_hit;
        v_hit = 1'b0;
        case (mode)
            EC_RISE: v_hit = trig & ~trig_q;
            EC_FALL: v_hit = ~trig & trig_q;
            EC_BOTH: v_hit = trig ^ trig_q;
            default: v_hit = 1'b0;
        endcase
        return v_hit;
    endfunction

endpackage

// File: rtl/edge_capture_bank_chan.sv
// One capture channel: strobe history, edge detect, single-entry capture slot and sticky overflow.
// Carries a timestamp alongside the captured word when EDGE_CAP_TSTAMP_EN is defined.
module edge_cap_chan import edge_cap_pkg::*; #(
    parameter int DW = EC_DW_DEF
`ifdef EDGE_CAP_TSTAMP_EN
    , parameter int TSW = EC_TSW_DEF
`endif
) (
    input  logic           clkin,
    input  logic           rst_n,
    input  logic           i_armed,
    input  logic           i_trig,
    input  ec_mode_e       i_mode,
    input  logic           i_clr,
    input  logic [DW-1:0]  i_data,
`ifdef EDGE_CAP_TSTAMP_EN
    input  logic [TSW-1:0] i_ts,
    output logic [TSW-1:0] o_ts,
`endif
    input  logic           i_unload,
    output logic           o_pending,
    output logic [DW-1:0]  o_cap,
    output logic           o_ovf
);

    logic          r_trig_q;
    logic          r_pending;
    logic          r_ovf;
    logic [DW-1:0] r_cap;
    logic          w_hit;
`ifdef EDGE_CAP_TSTAMP_EN
    logic [TSW-1:0] r_ts;
`endif

    assign w_hit = i_armed && ec_hit(i_mode, i_trig, r_trig_q);

    // Clear wins over a hit; a hit while the slot is being unloaded refills it without overflow.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_q  <= 1'b0;
            r_pending <= 1'b0;
            r_ovf     <= 1'b0;
            r_cap     <= '0;
`ifdef EDGE_CAP_TSTAMP_EN
            r_ts      <= '0;
`endif
        end else begin
            r_trig_q <= i_trig;
            if (i_clr) begin
                r_cap     <= '0;
                r_pending <= 1'b0;
                r_ovf     <= 1'b0;
`ifdef EDGE_CAP_TSTAMP_EN
                r_ts      <= '0;
`endif
            end else if (w_hit && (!r_pending || i_unload)) begin
                r_cap     <= i_data;
                r_pending <= 1'b1;
`ifdef EDGE_CAP_TSTAMP_EN
                r_ts      <= i_ts;
`endif
            end else if (w_hit) begin
                r_ovf <= 1'b1;
            end else if (i_unload) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_cap     = r_cap;
    assign o_ovf     = r_ovf;
`ifdef EDGE_CAP_TSTAMP_EN
    assign o_ts      = r_ts;
`endif

endmodule

// File: rtl/edge_capture_bank.sv
// Multi-channel edge capture bank with a round-robin drained valid/ready output port.
// Define EDGE_CAP_TSTAMP_EN to add a free-running timestamp captured with each event (out_ts).
module edge_capture_bank import edge_cap_pkg::*; #(
    parameter int NCH = EC_NCH_DEF,
    parameter int DW  = EC_DW_DEF
`ifdef EDGE_CAP_TSTAMP_EN
    , parameter int TSW = EC_TSW_DEF
`endif
) (
    input  logic                                  clkin,
    input  logic                                  rst_n,
    input  logic [NCH-1:0]                        trig_i,
    input  logic [2*NCH-1:0]                      mode_i,
    input  logic [NCH-1:0]                        clr_i,
    input  logic [NCH*DW-1:0]                     data_i,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
    output logic [DW-1:0]                         out_data,
`ifdef EDGE_CAP_TSTAMP_EN
    output logic [TSW-1:0]                        out_ts,
`endif
    output logic [NCH-1:0]                        ovf_o
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           r_armed;
    logic           r_valid;
    logic [CHW-1:0] r_ch;
    logic [DW-1:0]  r_data;
    logic [CHW-1:0] r_rr;

    logic [NCH-1:0] w_pending;
    logic [NCH-1:0] w_unload;
    logic [DW-1:0]  w_cap [NCH];
    logic           w_found_hi;
    logic           w_found;
    logic [CHW-1:0] w_win_hi;
    logic [CHW-1:0] w_win_lo;
    logic [CHW-1:0] w_winner;
    logic [CHW-1:0] w_rr_next;
    logic           w_load;

`ifdef EDGE_CAP_TSTAMP_EN
    logic [TSW-1:0] r_ts_cnt;
    logic [TSW-1:0] r_ts;
    logic [TSW-1:0] w_cap_ts [NCH];

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) r_ts_cnt <= '0;
        else        r_ts_cnt <= r_ts_cnt + 1'b1;
    end
`endif

    // The first clock after reset only primes the strobe history.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) r_armed <= 1'b0;
        else        r_armed <= 1'b1;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        assign w_unload[k] = w_load && (w_winner == CHW'(k));

        edge_cap_chan #(
            .DW  (DW)
`ifdef EDGE_CAP_TSTAMP_EN
            , .TSW (TSW)
`endif
        ) u_chan (
            .clkin     (clkin),
            .rst_n     (rst_n),
            .i_armed   (r_armed),
            .i_trig    (trig_i[k]),
            .i_mode    (ec_mode_e'(mode_i[2*k +: 2])),
            .i_clr     (clr_i[k]),
            .i_data    (data_i[k*DW +: DW]),
`ifdef EDGE_CAP_TSTAMP_EN
            .i_ts      (r_ts_cnt),
            .o_ts      (w_cap_ts[k]),
`endif
            .i_unload  (w_unload[k]),
            .o_pending (w_pending[k]),
            .o_cap     (w_cap[k]),
            .o_ovf     (ovf_o[k])
        );
    end

    // Lowest pending index at or after r_rr; otherwise wrap to the lowest pending overall.
    always_comb begin
        w_found_hi = 1'b0;
        w_found    = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_found  = 1'b1;
                w_win_lo = CHW'(i);
                if (CHW'(i) >= r_rr) begin
                    w_found_hi = 1'b1;
                    w_win_hi   = CHW'(i);
                end
            end
        end
        w_winner  = w_found_hi ? w_win_hi : w_win_lo;
        w_rr_next = (w_winner == CHW'(NCH - 1)) ? '0 : w_winner + 1'b1;
    end

    // Valid/ready: a word transfers on a cycle with out_valid && out_ready; while out_valid && !out_ready
    // all out_* hold, and out_valid falls only after a transfer with nothing left pending.
    assign w_load = (!r_valid || out_ready) && w_found;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_data  <= '0;
            r_rr    <= '0;
`ifdef EDGE_CAP_TSTAMP_EN
            r_ts    <= '0;
`endif
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_ch    <= w_winner;
            r_data  <= w_cap[w_winner];
            r_rr    <= w_rr_next;
`ifdef EDGE_CAP_TSTAMP_EN
            r_ts    <= w_cap_ts[w_winner];
`endif
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_ch    = r_ch;
    assign out_data  = r_data;
`ifdef EDGE_CAP_TSTAMP_EN
    assign out_ts    = r_ts;
`endif

endmodule

// File: tb/tb_edge_capture_bank.sv
// Directed bench for edge_capture_bank (4 channels, 7-bit data); checks out_ts when EDGE_CAP_TSTAMP_EN is defined.
module tb_edge_capture_bank;

    localparam int NCH = 4;
    localparam int DW  = 7;

    logic              clkin;
    logic              rst_n;
    logic [NCH-1:0]    trig_i;
    logic [2*NCH-1:0]  mode_i;
    logic [NCH-1:0]    clr_i;
    logic [NCH*DW-1:0] data_i;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_ch;
    logic [DW-1:0]     out_data;
    logic [NCH-1:0]    ovf_o;
`ifdef EDGE_CAP_TSTAMP_EN
    logic [15:0]       out_ts;
    logic [15:0]       ts_m;
    logic [15:0]       exp_ts;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_q[$];

    edge_capture_bank #(.NCH(NCH), .DW(DW)) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .trig_i    (trig_i),
        .mode_i    (mode_i),
        .clr_i     (clr_i),
        .data_i    (data_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
`ifdef EDGE_CAP_TSTAMP_EN
        .out_ts    (out_ts),
`endif
        .ovf_o     (ovf_o)
    );

    // clock / reset
    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

`ifdef EDGE_CAP_TSTAMP_EN
    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) ts_m <= '0;
        else        ts_m <= ts_m + 16'd1;
    end
`endif

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    function automatic logic [NCH*DW-1:0] pk(input logic [6:0] d3, input logic [6:0] d2,
                                             input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // drain exp_q, one word per cycle with out_ready held high
    task automatic drain(input string tag);
        logic [8:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_ch"}, 32'(out_ch), 32'(e[8:7]));
            chk({tag, "_data"}, 32'(out_data), 32'(e[6:0]));
            tick();
        end
        chk({tag, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; trig_i = '0; mode_i = '0; clr_i = '0; data_i = '0; out_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ch",    32'(out_ch),    32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_ovf",   32'(ovf_o),     32'd0);

        // release with strobes high, all BOTH: arming cycle must not see an edge
        trig_i = 4'b1111; mode_i = 8'hFF;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arm_novalid", 32'(out_valid), 32'd0);
        end

        // simultaneous falling edge on all channels, rr = 0
        out_ready = 1'b1;
        data_i = pk(7'h04, 7'h03, 7'h02, 7'h01);
        trig_i = 4'b0000;
        tick();
        chk("burst1_lat", 32'(out_valid), 32'd0);
        tick();
        exp_q.push_back({2'd0, 7'h01});
        exp_q.push_back({2'd1, 7'h02});
        exp_q.push_back({2'd2, 7'h03});
        exp_q.push_back({2'd3, 7'h04});
        drain("burst1");

        // single ch2 event moves rr to 3
        data_i = pk(7'h00, 7'h0A, 7'h00, 7'h00);
        trig_i = 4'b0100;
        tick(); tick();
        exp_q.push_back({2'd2, 7'h0A});
        drain("single2");

        // second burst (ch0, ch1, ch3) starts from rr = 3
        data_i = pk(7'h34, 7'h00, 7'h32, 7'h31);
        trig_i = 4'b1111;
        tick(); tick();
        exp_q.push_back({2'd3, 7'h34});
        exp_q.push_back({2'd0, 7'h31});
        exp_q.push_back({2'd1, 7'h32});
        drain("burst2");

        // ch0 RISE with 7'h55, two-cycle latency
        mode_i = 8'h00; trig_i = 4'b0000;
        tick();
        mode_i = 8'h01;
        data_i = pk(7'h00, 7'h00, 7'h00, 7'h55);
        trig_i = 4'b0001;
        tick();
        chk("rise0_lat", 32'(out_valid), 32'd0);
`ifdef EDGE_CAP_TSTAMP_EN
        exp_ts = ts_m - 16'd1;
`endif
        tick();
        chk("rise0_valid", 32'(out_valid), 32'd1);
        chk("rise0_ch",    32'(out_ch),    32'd0);
        chk("rise0_data",  32'(out_data),  32'h55);
`ifdef EDGE_CAP_TSTAMP_EN
        chk("rise0_ts",    32'(out_ts),    32'(exp_ts));
`endif
        tick();
        chk("rise0_idle", 32'(out_valid), 32'd0);

        // ch1 FALL with a stalled port: 11 held, 33 queued, 22 dropped -> overflow
        mode_i = 8'h08; out_ready = 1'b0;
        trig_i = 4'b0011;
        tick();
        data_i = pk(7'h00, 7'h00, 7'h11, 7'h00);
        trig_i = 4'b0001;
        tick(); tick();
        chk("fall1_valid", 32'(out_valid), 32'd1);
        chk("fall1_data",  32'(out_data),  32'h11);
        chk("fall1_ch",    32'(out_ch),    32'd1);
        trig_i = 4'b0011;
        tick();
        data_i = pk(7'h00, 7'h00, 7'h33, 7'h00);
        trig_i = 4'b0001;
        tick();
        chk("fall1_noovf", 32'(ovf_o), 32'd0);
        trig_i = 4'b0011;
        tick();
        data_i = pk(7'h00, 7'h00, 7'h22, 7'h00);
        trig_i = 4'b0001;
        tick();
        chk("fall1_ovf",  32'(ovf_o),    32'b0010);
        chk("fall1_hold", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        tick();
        exp_q.push_back({2'd1, 7'h33});
        drain("fall1_q");
        chk("fall1_sticky", 32'(ovf_o), 32'b0010);

        // ch2: held output, pending + overflow, then clear with a simultaneous edge
        out_ready = 1'b0; mode_i = 8'h30;
        data_i = pk(7'h00, 7'h41, 7'h00, 7'h00);
        trig_i = 4'b0101;
        tick(); tick();
        chk("clr2_valid", 32'(out_valid), 32'd1);
        chk("clr2_data",  32'(out_data),  32'h41);
        data_i = pk(7'h00, 7'h42, 7'h00, 7'h00);
        trig_i = 4'b0001;
        tick();
        data_i = pk(7'h00, 7'h43, 7'h00, 7'h00);
        trig_i = 4'b0101;
        tick();
        chk("clr2_ovf_set", 32'(ovf_o), 32'b0110);
        data_i = pk(7'h00, 7'h44, 7'h00, 7'h00);
        trig_i = 4'b0001; clr_i = 4'b0100;
        tick();
        clr_i = 4'b0000;
        chk("clr2_ovf_clr", 32'(ovf_o),    32'b0010);
        chk("clr2_keep",    32'(out_data), 32'h41);
        out_ready = 1'b1;
        tick();
        chk("clr2_none_a", 32'(out_valid), 32'd0);
        tick();
        chk("clr2_none_b", 32'(out_valid), 32'd0);

        // asynchronous reset while stalled
        out_ready = 1'b0; mode_i = 8'hC0;
        data_i = pk(7'h7F, 7'h00, 7'h00, 7'h00);
        trig_i = 4'b1001;
        tick(); tick();
        chk("arst_pre_valid", 32'(out_valid), 32'd1);
        chk("arst_pre_data",  32'(out_data),  32'h7F);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ovf",   32'(ovf_o),     32'd0);
        chk("arst_data",  32'(out_data),  32'd0);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
